// File: rtl/filter_stream.sv
// ---------------------------------------------------------------------------
// filter_stream
//
// Streaming exact-match key filter built from TABLES parallel hash tables.
// Every accepted key is hashed once per table (a different rotation per
// table). All tables are read in the same cycle, and the lowest-numbered
// table that holds a valid entry with an equal key supplies the data word.
//
// Pipeline (one key per cycle; all stages advance together):
//   stage 1 : hash + registered table read, captured on the acceptance edge
//   stage 2 : key compare + priority select, registered
//   output  : output register, held while the consumer stalls
// A key accepted at edge n is presented after edge n+2 when nothing stalls.
//
// After reset an INIT sweep clears one address per cycle in every table.
// Keys and configuration writes are ignored until the sweep completes.
//
// Optional feature: define FILTER_STREAM_STATS_EN to build the hit/miss
// counters. Without it, stat_hits/stat_misses read zero and stat_clear is
// ignored.
//
// Ports
//   clk                   sole clock, rising edge
//   reset                 synchronous, active-low
//   input_key/_valid/_ready        lookup request stream
//   output_key/_data/_key_found    lookup result (data is zero on miss)
//   output_valid/_ready            result stream handshake
//   config_key/_data/_empty        rule contents (empty=1 invalidates)
//   config_address_table/_item     target entry of a rule write
//   config_write                   rule write strobe, one entry per cycle
//   stat_hits/stat_misses          saturating 32-bit counters
//   stat_clear                     zeroes both counters (wins over counting)
// ---------------------------------------------------------------------------
module filter_stream #(
    parameter int KEY_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int TABLES     = 4,
    parameter int TABLE_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [KEY_WIDTH-1:0]          input_key,
    input  logic                          input_valid,
    output logic                          input_ready,
    output logic [KEY_WIDTH-1:0]          output_key,
    output logic [DATA_WIDTH-1:0]         output_data,
    output logic                          output_key_found,
    output logic                          output_valid,
    input  logic                          output_ready,
    input  logic [KEY_WIDTH-1:0]          config_key,
    input  logic [DATA_WIDTH-1:0]         config_data,
    input  logic                          config_empty,
    input  logic [$clog2(TABLES)-1:0]     config_address_table,
    input  logic [$clog2(TABLE_SIZE)-1:0] config_address_item,
    input  logic                          config_write,
    output logic [31:0]                   stat_hits,
    output logic [31:0]                   stat_misses,
    input  logic                          stat_clear
);

    localparam int AW        = $clog2(TABLE_SIZE);
    localparam int TW        = $clog2(TABLES);
    localparam int NCHUNK    = (KEY_WIDTH + AW - 1) / AW;
    localparam int PAD_WIDTH = NCHUNK * AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TABLE_SIZE - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Index for one table: rotate the key left by `rot`, zero-pad it to a
    // whole number of AW-bit chunks, then fold the chunks together with XOR.
    function automatic logic [AW-1:0] hash_index(input logic [KEY_WIDTH-1:0] key,
                                                 input int unsigned          rot);
        logic [PAD_WIDTH-1:0] padded;
        logic [AW-1:0]        h;
        padded = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            padded[(i + rot) % KEY_WIDTH] = key[i];
        end
        h = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            h = h ^ padded[c*AW +: AW];
        end
        return h;
    endfunction

    // -----------------------------------------------------------------------
    // Control FSM: INIT sweep, then RUN until the next reset
    // -----------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [AW-1:0] sweep_addr;
    logic [AW-1:0] sweep_next;
    logic          sweep_active;
    logic          run_active;
    logic          advance;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_next;
            sweep_addr <= sweep_next;
        end
    end

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sweep_next = sweep_addr;
        case (state)
            ST_INIT: begin
                sweep_next = sweep_addr + 1'b1;
                if (sweep_addr == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_comb begin
        sweep_active = (state == ST_INIT);
        run_active   = (state == ST_RUN);
    end

    // The whole pipeline moves only when the output register is free or
    // being drained this cycle; bubbles move with it.
    assign advance     = !output_valid || output_ready;
    assign input_ready = advance && run_active;

    // -----------------------------------------------------------------------
    // Table write port: the sweep owns it during INIT, config writes in RUN
    // -----------------------------------------------------------------------
    logic          cfg_accept;
    logic [AW-1:0] wr_addr;
    entry_t        wr_entry;

    assign cfg_accept = run_active && config_write;
    assign wr_addr    = sweep_active ? sweep_addr : config_address_item;

    always_comb begin
        wr_entry = '0;
        if (!sweep_active) begin
            wr_entry.valid = !config_empty;
            wr_entry.key   = config_key;
            wr_entry.data  = config_data;
        end
    end

    // -----------------------------------------------------------------------
    // Tables and stage 1 (registered read)
    // -----------------------------------------------------------------------
    logic                  s1_valid;
    logic [KEY_WIDTH-1:0]  s1_key;
    logic [TABLES-1:0]     hit_vec;
    logic [DATA_WIDTH-1:0] hit_data [TABLES];

    for (genvar t = 0; t < TABLES; t++) begin : g_table
        entry_t        mem [TABLE_SIZE];
        entry_t        rd_q;
        logic [AW-1:0] rd_idx;
        logic          wr_en;

        assign rd_idx = hash_index(input_key, t);
        assign wr_en  = sweep_active || (cfg_accept && (config_address_table == TW'(t)));

        // NOTE: table storage and its read register carry no reset; the INIT
        // sweep invalidates the contents and the stage valids gate the data.
        // Reading and writing in one block makes a same-entry collision
        // return the old contents. The read register holds while stalled,
        // so config writes can land without disturbing keys already read.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_entry;
            end
            if (advance) begin
                rd_q <= mem[rd_idx];
            end
        end

        assign hit_vec[t]  = rd_q.valid && (rd_q.key == s1_key);
        assign hit_data[t] = rd_q.data;
    end

    // -----------------------------------------------------------------------
    // Stage 2: priority select, lowest-numbered hitting table wins
    // -----------------------------------------------------------------------
    logic                  hit_found;
    logic [DATA_WIDTH-1:0] hit_sel_data;

    always_comb begin
        hit_found    = 1'b0;
        hit_sel_data = '0;
        for (int t = TABLES - 1; t >= 0; t--) begin
            if (hit_vec[t]) begin
                hit_found    = 1'b1;
                hit_sel_data = hit_data[t];
            end
        end
    end

    logic                  s2_valid;
    logic [KEY_WIDTH-1:0]  s2_key;
    logic                  s2_found;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid         <= 1'b0;
            s1_key           <= '0;
            s2_valid         <= 1'b0;
            s2_key           <= '0;
            s2_found         <= 1'b0;
            s2_data          <= '0;
            output_valid     <= 1'b0;
            output_key       <= '0;
            output_key_found <= 1'b0;
            output_data      <= '0;
        end else if (advance) begin
            s1_valid         <= input_valid && input_ready;
            s1_key           <= input_key;
            s2_valid         <= s1_valid;
            s2_key           <= s1_key;
            s2_found         <= s1_valid && hit_found;
            s2_data          <= (s1_valid && hit_found) ? hit_sel_data : '0;
            output_valid     <= s2_valid;
            output_key       <= s2_key;
            output_key_found <= s2_found;
            output_data      <= s2_data;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef FILTER_STREAM_STATS_EN
    logic out_fire;
    assign out_fire = output_valid && output_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (stat_clear) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (out_fire) begin
            if (output_key_found) begin
                if (stat_hits != '1) begin
                    stat_hits <= stat_hits + 32'd1;
                end
            end else begin
                if (stat_misses != '1) begin
                    stat_misses <= stat_misses + 32'd1;
                end
            end
        end
    end
`else
    logic unused_stat_clear;
    assign unused_stat_clear = stat_clear;
    assign stat_hits         = '0;
    assign stat_misses       = '0;
`endif

endmodule
